// File: rtl/sb_pkg.sv
// Shared types and default widths for the store buffer.
package sb_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 10;

  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding matcher: returns the youngest valid buffered entry whose address equals
// the load address.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  sb_entry_t            entries_i [DEPTH],
  input  logic [DEPTH-1:0]     valid_i,
  input  logic [PtrW-1:0]      head_i,
  input  logic [DefAddrW-1:0]  ld_addr_i,
  output logic                 hit_o,
  output logic [DefDataW-1:0]  data_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PtrW'(k);
      if (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store queue between execute and data memory: in-order FIFO drain with youngest-match
// load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stReq,
  input  logic [ADDR_W-1:0] stAddr,
  input  logic [DATA_W-1:0] stDat,
  output logic              stReady,
  input  logic              ldReq,
  input  logic [ADDR_W-1:0] ldAddr,
  output logic [DATA_W-1:0] ldDat,
  output logic              ldHit,
  input  logic              flush,
  output logic              empty,
  output logic [CntW-1:0]   count,
  output logic              dmWrite,
  output logic [ADDR_W-1:0] dmWrDat_addr,
  output logic [DATA_W-1:0] dmWrDat,
  output logic [ADDR_W-1:0] dmReDat_addr,
  input  logic [DATA_W-1:0] dmReDat
);

  // Entry storage uses sb_entry_t, so DATA_W/ADDR_W must match the package widths.
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  sb_entry_t       entries_q [DEPTH];

  logic             full;
  logic             push;
  logic             drain;
  logic [DEPTH-1:0] valid;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign stReady = !full && !flush;
  assign push    = stReq && stReady;
  // Loads own the memory port unless the buffer must make room or is flushing.
  assign drain   = !empty && (flush || full || !ldReq);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= '{addr: stAddr, data: stDat};
    end
  end

  // An entry is valid when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = CntW'(PtrW'(PtrW'(i) - rd_ptr_q)) < count_q;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .entries_i (entries_q),
    .valid_i   (valid),
    .head_i    (rd_ptr_q),
    .ld_addr_i (ldAddr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign ldHit        = ldReq && fwd_hit;
  assign ldDat        = ldHit ? fwd_data : dmReDat;
  assign count        = count_q;
  assign dmWrite      = drain;
  assign dmWrDat_addr = entries_q[rd_ptr_q].addr;
  assign dmWrDat      = entries_q[rd_ptr_q].data;
  assign dmReDat_addr = ldAddr;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data memory.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        stReq;
  logic [9:0]  stAddr;
  logic [15:0] stDat;
  logic        stReady;
  logic        ldReq;
  logic [9:0]  ldAddr;
  logic [15:0] ldDat;
  logic        ldHit;
  logic        flush;
  logic        empty;
  logic [2:0]  count;
  logic        dmWrite;
  logic [9:0]  dmWrDat_addr;
  logic [15:0] dmWrDat;
  logic [9:0]  dmReDat_addr;
  logic [15:0] dmReDat;

  bit [15:0]   mem [1024];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [15:0] pre_dat;

  int n_checks;
  int n_fail;

  store_buffer #(
    .DEPTH  (4),
    .DATA_W (16),
    .ADDR_W (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stReq        (stReq),
    .stAddr       (stAddr),
    .stDat        (stDat),
    .stReady      (stReady),
    .ldReq        (ldReq),
    .ldAddr       (ldAddr),
    .ldDat        (ldDat),
    .ldHit        (ldHit),
    .flush        (flush),
    .empty        (empty),
    .count        (count),
    .dmWrite      (dmWrite),
    .dmWrDat_addr (dmWrDat_addr),
    .dmWrDat      (dmWrDat),
    .dmReDat_addr (dmReDat_addr),
    .dmReDat      (dmReDat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmWrite) mem[dmWrDat_addr] <= dmWrDat;
    if (pre_we) mem[pre_addr] <= pre_dat;
  end
  assign dmReDat = mem[dmReDat_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    stReq    = 1'b0;
    stAddr   = '0;
    stDat    = '0;
    ldReq    = 1'b0;
    ldAddr   = '0;
    flush    = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_dat  = '0;

    #3;
    check_eq("rst_empty", empty, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_ready", stReady, 1);
    check_eq("rst_dmwrite", dmWrite, 0);
    check_eq("rst_ldhit", ldHit, 0);
    #4 rst_n = 1'b1;
    tick();

    // Reset mid-drain with three entries buffered
    stReq  = 1'b1;
    ldReq  = 1'b1;
    ldAddr = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      stAddr = 10'(k + 1);
      stDat  = 16'h0100 + 16'(k);
      tick();
    end
    stReq = 1'b0;
    ldReq = 1'b0;
    #1;
    check_eq("pre_rst_count", count, 3);
    check_eq("pre_rst_dmwrite", dmWrite, 1);
    check_eq("pre_rst_head", dmWrDat_addr, 10'h001);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_empty", empty, 1);
    check_eq("async_rst_count", count, 0);
    check_eq("async_rst_dmwrite", dmWrite, 0);
    #1 rst_n = 1'b1;
    #1;
    stReq  = 1'b1;
    stAddr = 10'h005;
    stDat  = 16'h0055;
    ldReq  = 1'b1;
    tick();
    stReq = 1'b0;
    check_eq("post_rst_slot0", dut.entries_q[0].addr, 10'h005);
    check_eq("post_rst_count", count, 1);
    check_eq("rst_no_stale_write", mem[10'h001], 16'h0000);
    ldReq = 1'b0;
    tick();
    check_eq("drain_005", mem[10'h005], 16'h0055);

    // Fill and stall with loads holding the port
    ldReq  = 1'b1;
    ldAddr = 10'h3FF;
    stReq  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stAddr = 10'h010 + 10'(k);
      stDat  = 16'hA000 + 16'(k);
      #1;
      check_eq($sformatf("fill_nodrain%0d", k), dmWrite, 0);
      tick();
    end
    stReq = 1'b0;
    #1;
    check_eq("full_count", count, 4);
    check_eq("full_ready", stReady, 0);
    check_eq("full_dmwrite", dmWrite, 1);
    check_eq("full_wr_addr", dmWrDat_addr, 10'h010);
    check_eq("full_wr_dat", dmWrDat, 16'hA000);
    tick();
    check_eq("full_after_count", count, 3);
    check_eq("full_mem010", mem[10'h010], 16'hA000);
    ldReq = 1'b0;
    tick();
    tick();
    tick();
    check_eq("fill_drained_empty", empty, 1);
    check_eq("fill_mem013", mem[10'h013], 16'hA003);

    // Miss path
    pre_we   = 1'b1;
    pre_addr = 10'h030;
    pre_dat  = 16'hBEEF;
    tick();
    pre_we = 1'b0;
    ldReq  = 1'b1;
    ldAddr = 10'h030;
    #1;
    check_eq("miss_hit", ldHit, 0);
    check_eq("miss_dat", ldDat, 16'hBEEF);
    check_eq("miss_rdaddr", dmReDat_addr, 10'h030);

    // Same-cycle store and load
    stReq  = 1'b1;
    stAddr = 10'h040;
    stDat  = 16'h5555;
    ldAddr = 10'h040;
    #1;
    check_eq("hazard_hit", ldHit, 0);
    check_eq("hazard_dat", ldDat, 16'h0000);
    tick();
    stReq = 1'b0;
    #1;
    check_eq("hazard_next_hit", ldHit, 1);
    check_eq("hazard_next_dat", ldDat, 16'h5555);
    ldReq = 1'b0;
    tick();
    check_eq("hazard_mem040", mem[10'h040], 16'h5555);

    // Youngest-match forwarding
    ldReq  = 1'b1;
    ldAddr = 10'h3FF;
    stReq  = 1'b1;
    stAddr = 10'h020;
    stDat  = 16'h1111;
    tick();
    stDat = 16'h2222;
    tick();
    stReq  = 1'b0;
    ldAddr = 10'h020;
    #1;
    check_eq("young_hit", ldHit, 1);
    check_eq("young_dat", ldDat, 16'h2222);
    ldReq = 1'b0;
    #1;
    check_eq("noreq_hit", ldHit, 0);
    tick();
    tick();
    check_eq("young_empty", empty, 1);
    check_eq("young_mem020", mem[10'h020], 16'h2222);

    // Prime head to 3 with overlapping push and pop
    stReq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stAddr = 10'h050 + 10'(k);
      stDat  = 16'(k);
      tick();
      check_eq($sformatf("pushpop_count%0d", k), count, 1);
    end
    stReq = 1'b0;
    tick();
    check_eq("prime_empty", empty, 1);
    check_eq("prime_head", dut.rd_ptr_q, 3);

    // Flush across the wrap point
    ldReq  = 1'b1;
    ldAddr = 10'h3FF;
    stReq  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stAddr = 10'h060 + 10'(k);
      stDat  = 16'hC000 + 16'(k);
      tick();
    end
    check_eq("wrap_count", count, 3);
    check_eq("wrap_tail", dut.wr_ptr_q, 2);
    flush  = 1'b1;
    stAddr = 10'h0FF;
    stDat  = 16'hDEAD;
    ldAddr = 10'h061;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("flush_ready%0d", k), stReady, 0);
      check_eq($sformatf("flush_dmwrite%0d", k), dmWrite, 1);
      check_eq($sformatf("flush_addr%0d", k), dmWrDat_addr, 10'h060 + 10'(k));
      check_eq($sformatf("flush_dat%0d", k), dmWrDat, 16'hC000 + 16'(k));
      if (k == 1) begin
        check_eq("drain_fwd_hit", ldHit, 1);
        check_eq("drain_fwd_dat", ldDat, 16'hC001);
      end
      if (k == 2) begin
        check_eq("drained_hit", ldHit, 0);
        check_eq("drained_dat", ldDat, 16'hC001);
      end
      tick();
    end
    #1;
    check_eq("flush_empty", empty, 1);
    check_eq("flush_count", count, 0);
    check_eq("flush_dmwrite_end", dmWrite, 0);
    flush = 1'b0;
    stReq = 1'b0;
    tick();
    check_eq("flush_refused", count, 0);
    check_eq("flush_mem0ff", mem[10'h0FF], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store queue between the processor's execute stage and the data memory. It accepts stores at one per cycle into a DEPTH-entry FIFO and drains them into the data memory's write port one per cycle. Loads are forwarded from the youngest matching buffered store, or otherwise served from the memory read port. Each buffered entry holds one 16-bit word and its 10-bit word address.

## Interface
- DEPTH, 4: buffer entries; power of two, at least 2.
- DATA_W, 16: data word width.
- ADDR_W, 10: word address width.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stReq  in  1  store request from execute.
- stAddr  in  ADDR_W  store word address.
- stDat  in  DATA_W  store data.
- stReady  out  1  buffer can accept a store this cycle.
- ldReq  in  1  load request from execute.
- ldAddr  in  ADDR_W  load word address.
- ldDat  out  DATA_W  load result, combinational.
- ldHit  out  1  ldDat was forwarded from the buffer.
- flush  in  1  level; drain the buffer to empty and block new stores.
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- dmWrite  out  1  write strobe to the data memory.
- dmWrDat_addr  out  ADDR_W  memory write address, driven from the head entry.
- dmWrDat  out  DATA_W  memory write data, driven from the head entry.
- dmReDat_addr  out  ADDR_W  memory read address; equals ldAddr.
- dmReDat  in  DATA_W  memory read data, combinational from memory.

## Operation
- **Push:** a store is accepted when stReq && stReady; it is written at the tail at the clock edge.
- **stReady:** `stReady = !full && !flush`.
- **Drain condition:** `drain = !empty && (flush || full || !ldReq)`.
  - Loads get the memory port ahead of drains unless the buffer is full or flushing.
- **Memory write:** dmWrite = drain, presented combinationally from the head entry. The head is popped at the same edge.
- **Forwarding:**
  - Compare ldAddr against all valid entries.
  - On any match: ldHit=1 and ldDat = data of the youngest matching entry (closest to the tail).
  - Otherwise: ldHit=0 and ldDat = dmReDat.
  - ldHit=0 whenever ldReq=0.
- **Store and load in the same cycle:** the load does not see the incoming store, because the store is not yet buffered.
- **Draining entry:** an entry that is draining this cycle still forwards this cycle. After the edge, the memory holds the value.
- **Push and pop in the same cycle:** count is unchanged and both pointers advance.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - full = (count == DEPTH).
  - empty = (count == 0).
- **Address range:** addresses are not range-checked; the full ADDR_W range is valid.
- **Duplicate addresses:** duplicate addresses are not merged; each drains separately in program order.

## Timing
- **Reset values:** pointers=0, count=0, empty=1, stReady=1, dmWrite=0, ldHit=0. Entry contents are not reset.
- **Reset mid-operation:** asserting rst_n low discards all buffered stores immediately, without waiting for a clock edge.
- **Store latency:** an accepted store is visible to forwarding in the next cycle. The earliest memory write is that same next cycle.
- **Load latency:** zero cycles; ldDat is combinational.
- **Drain rate:** at most one entry per cycle. When the buffer is full, an entry drains in every cycle.
- **Flush:** with flush held, the buffer empties in exactly count cycles and empty rises after the last pop. Stores are refused while flush is high.
- **Registered state:** the pointers, count, and entry array only. All other outputs are combinational from this state and the inputs.

## Structure
- **Package sb_pkg:** DATA_W and ADDR_W defaults, plus `typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} sb_entry_t`.
- **Sub-module sb_fwd_match:**
  - Inputs: entry array, valid vector, head pointer, ldAddr.
  - Outputs: hit and data.
  - Priority selection of the youngest match.
- **Top level:** holds the FIFO pointers, count, drain/push control, and the memory-side muxing.

## Test plan
- **Reset:** assert rst_n=0 mid-drain with 3 entries -> empty=1, count=0, dmWrite=0 immediately. The next store to 0x005 lands in entry 0.
- **Fill and stall:** push 4 stores (0x010..0x013, data 0xA000..0xA003) with ldReq=1 throughout.
  - No drains occur until full; stReady=0 at count=4.
  - A drain of 0x010/0xA000 occurs in that cycle despite ldReq.
- **Youngest-match forwarding:** store 0x020←0x1111, then 0x020←0x2222, then load 0x020 with ldReq held -> ldHit=1, ldDat=0x2222.
- **Miss path:** memory[0x030]=0xBEEF, buffer empty, load 0x030 -> ldHit=0, ldDat=0xBEEF.
- **Same-cycle hazard:** in one cycle, store 0x040←0x5555 and load 0x040 with memory holding 0x0000 -> ldDat=0x0000, ldHit=0. A load the next cycle returns 0x5555.
- **Flush and wrap:**
  - Prime the pointers to head=3, then push 3 stores so the buffer wraps.
  - Raise flush with ldReq=1 -> exactly 3 dmWrite cycles in program order, stReady=0 throughout, empty=1 afterwards.
